// File: rtl/bus_decoder.sv
// rtl/bus_decoder.sv - memory-map decoder and busy/ready sequencer between the CPU bus and NREG targets
module bus_decoder #(
    parameter int                  AW        = 16,
    parameter int                  DW        = 16,
    parameter int                  NREG      = 4,
    parameter logic [NREG*AW-1:0]  REG_BASE  = {16'h4C00, 16'h1000, 16'h0003, 16'h0000},
    parameter logic [NREG*AW-1:0]  REG_LIMIT = {16'hFFFF, 16'h4BFF, 16'h0FFF, 16'h0002},
    parameter logic [NREG-1:0]     REG_RO    = 4'b0000,
    parameter logic [NREG-1:0]     REG_WO    = 4'b0100,
    parameter logic [NREG-1:0]     REG_IX    = 4'b1000,
    parameter int                  TIMEOUT   = 255,
    parameter int                  TW        = 8
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    input  logic                 rd,
    input  logic                 wr,
    input  logic                 instr,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 ready,
    output logic                 err,
    output logic [AW-1:0]        t_addr,
    output logic [DW-1:0]        t_wdata,
    output logic [NREG-1:0]      t_rd,
    output logic [NREG-1:0]      t_wr,
    input  logic [NREG*DW-1:0]   t_rdata,
    input  logic [NREG-1:0]      t_busy,
    input  logic [NREG-1:0]      t_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [NREG-1:0] sel_oh;
    logic            sel_wr;
    logic [TW-1:0]   cnt;

    logic            hit_any, hit_ro, hit_wo, hit_ix;
    logic [NREG-1:0] hit_oh;
    logic [AW-1:0]   hit_base;
    logic            dec_err, req;
    logic            sel_ready, sel_busy, complete, timeout_hit;
    logic [DW-1:0]   sel_rdata;

    // Scan from the top so the lowest matching region is the last one written.
    always_comb begin
        hit_any  = 1'b0;
        hit_oh   = '0;
        hit_base = '0;
        hit_ro   = 1'b0;
        hit_wo   = 1'b0;
        hit_ix   = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (addr >= REG_BASE[i*AW +: AW] && addr <= REG_LIMIT[i*AW +: AW]) begin
                hit_any  = 1'b1;
                hit_oh   = '0;
                hit_oh[i] = 1'b1;
                hit_base = REG_BASE[i*AW +: AW];
                hit_ro   = REG_RO[i];
                hit_wo   = REG_WO[i];
                hit_ix   = REG_IX[i];
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_busy  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_oh[i]) begin
                sel_ready = t_ready[i];
                sel_busy  = t_busy[i];
                sel_rdata = t_rdata[i*DW +: DW];
            end
        end
    end

    assign req         = rd | wr;
    assign dec_err     = !hit_any || (rd && wr) || (wr && hit_ro) || (rd && hit_wo) || (instr && !hit_ix);
    assign complete    = sel_ready && !sel_busy;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = dec_err ? DONE : ACCESS;
            ACCESS:  if (complete || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state   <= IDLE;
            rdata   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            t_rd    <= '0;
            t_wr    <= '0;
            t_addr  <= '0;
            t_wdata <= '0;
            cnt     <= '0;
            sel_oh  <= '0;
            sel_wr  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ACCESS);
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        sel_oh  <= hit_oh;
                        sel_wr  <= wr;
                        t_addr  <= addr - hit_base;
                        t_wdata <= wdata;
                        cnt     <= '0;
                        if (dec_err) begin
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            t_rd <= rd ? hit_oh : '0;
                            t_wr <= wr ? hit_oh : '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (complete) begin
                        t_rd  <= '0;
                        t_wr  <= '0;
                        ready <= 1'b1;
                        rdata <= sel_wr ? '0 : sel_rdata;
                    end else if (timeout_hit) begin
                        t_rd  <= '0;
                        t_wr  <= '0;
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end
endmodule
